// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: parses START/count/payload frames, writes big-endian
// 16-bit words from address 0 and holds the CPU until loaded. Optional checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int          ADDR_W     = 10,
  parameter logic [7:0]  START_BYTE = 8'hA5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);
  typedef enum logic [3:0] {
    IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE, ERROR
  } state_t;

  localparam logic [16:0] MAX_CNT = 17'(2**ADDR_W);

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [7:0]        hi_q, hi_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              fire;
  logic [15:0]       cnt_new;
  logic [ADDR_W:0]   idx_inc;

  // Ready is a pure state decode so it never depends on in_valid.
  assign in_ready     = (state_q != WRITE) && (state_q != DONE);
  assign fire         = in_valid && in_ready;
  assign cnt_new      = {cnt_q[15:8], in_data};
  assign idx_inc      = idx_q + 1'b1;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_hold     = (state_q != DONE);
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERROR);
  assign words_loaded = idx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE, ERROR: if (fire && in_data == START_BYTE) begin
        state_d = CNT_HI;
        idx_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = '0;
`endif
      end
      CNT_HI: if (fire) begin
        cnt_d   = {in_data, cnt_q[7:0]};
        state_d = CNT_LO;
      end
      CNT_LO: if (fire) begin
        cnt_d   = cnt_new;
        state_d = (cnt_new == 16'd0 || {1'b0, cnt_new} > MAX_CNT) ? ERROR : DATA_HI;
      end
      DATA_HI: if (fire) begin
        hi_d    = in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q ^ in_data;
`endif
        state_d = DATA_LO;
      end
      // Write strobe, address and data are all registered here so WRITE sees clean flop outputs.
      DATA_LO: if (fire) begin
        we_d    = 1'b1;
        addr_d  = idx_q[ADDR_W-1:0];
        wdata_d = {hi_q, in_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q ^ in_data;
`endif
        state_d = WRITE;
      end
      WRITE: begin
        idx_d = idx_inc;
        if (17'(idx_inc) == 17'(cnt_q)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = DATA_HI;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: if (fire) state_d = (in_data == csum_q) ? DONE : ERROR;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by stimulus, a monitor pops on imem_we.
module tb_imem_loader;
  localparam int ADDR_W = 10;

  logic              clock = 1'b0;
  logic              reset;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W), .START_BYTE(8'hA5)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [ADDR_W-1:0] addr; logic [15:0] data; } wr_t;
  wr_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    wr_t w;
    forever begin
      @(negedge clock);
      if (!reset && imem_we) begin
        if (sb.size() == 0) check("unexpected_write", {6'd0, imem_addr, imem_wdata}, 32'hFFFF_FFFF);
        else begin
          w = sb.pop_front();
          check("wr_addr", 32'(imem_addr), 32'(w.addr));
          check("wr_data", 32'(imem_wdata), 32'(w.data));
        end
      end
      if (!reset && !in_ready && !done) check("ready_low_only_in_write", 32'(imem_we), 32'd1);
    end
  endtask

  // Starts and ends on a negedge; the byte is consumed on the posedge in between.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clock);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clock); n++; end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (!done && !error && n < 20) begin @(negedge clock); n++; end
    check("end_reached", 32'(done | error), 32'd1);
    repeat (2) @(negedge clock);
  endtask

  task automatic push(input int a, input logic [15:0] d);
    wr_t w;
    w.addr = ADDR_W'(a); w.data = d;
    sb.push_back(w);
  endtask

  task automatic two_word(input int gap);
    push(0, 16'h410F); push(1, 16'h4207);
    send(8'hA5, gap); send(8'h00, gap); send(8'h02, gap);
    send(8'h41, gap); send(8'h0F, gap); send(8'h42, gap); send(8'h07, gap);
  endtask

  task automatic check_done(input string tag, input int words);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'(words));
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    fork monitor(); join_none
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", 32'(imem_wdata), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);

    // Back-to-back two-word program
    two_word(0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h0B, 0);
`endif
    wait_end();
    check_done("two_word", 2);
    repeat (3) @(negedge clock);
    check("done_sticky", 32'(done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum: words still written, frame rejected
    do_reset();
    two_word(0);
    send(8'h0C, 0);
    wait_end();
    check("bad_csum_error", 32'(error), 32'd1);
    check("bad_csum_hold", 32'(cpu_hold), 32'd1);
    check("bad_csum_done", 32'(done), 32'd0);
    check("bad_csum_sb_empty", 32'(sb.size()), 32'd0);
`endif

    // Bad counts then recovery
    do_reset();
    send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0);
    wait_end();
    check("cnt0_error", 32'(error), 32'd1);
    check("cnt0_hold", 32'(cpu_hold), 32'd1);
    check("cnt0_in_ready", 32'(in_ready), 32'd1);
    send(8'h77, 0);
    check("err_discard", 32'(error), 32'd1);
    send(8'hA5, 0); send(8'h04, 0); send(8'h01, 0);
    wait_end();
    check("cnt401_error", 32'(error), 32'd1);
    push(0, 16'h410F);
    send(8'hA5, 0); send(8'h00, 0); send(8'h01, 0); send(8'h41, 0); send(8'h0F, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h4E, 0);
`endif
    wait_end();
    check_done("recover", 1);

    // Garbage before start and random stalls between bytes
    do_reset();
    send(8'h00, 1); send(8'hFF, 2); send(8'h13, 3);
    check("garbage_idle_words", 32'(words_loaded), 32'd0);
    two_word($urandom_range(1, 3));
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h0B, 3);
`endif
    wait_end();
    check_done("stall", 2);

    // Reset one cycle after the first write
    do_reset();
    push(0, 16'h410F);
    send(8'hA5, 0); send(8'h00, 0); send(8'h02, 0); send(8'h41, 0); send(8'h0F, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_we", 32'(imem_we), 32'd0);
    check("midrst_words", 32'(words_loaded), 32'd0);
    check("midrst_hold", 32'(cpu_hold), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    check("midrst_sb_empty", 32'(sb.size()), 32'd0);
    two_word(0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h0B, 0);
`endif
    wait_end();
    check_done("after_midrst", 2);

    // Full depth: 1024 words, word i = i
    do_reset();
    begin
      logic [7:0] cs;
      logic [15:0] w;
      cs = 8'h00;
      send(8'hA5, 0); send(8'h04, 0); send(8'h00, 0);
      for (int i = 0; i < 1024; i++) begin
        w = 16'(i);
        push(i, w);
        send(w[15:8], 0); send(w[7:0], 0);
        cs = cs ^ w[15:8] ^ w[7:0];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(cs, 0);
`endif
    end
    wait_end();
    check("full_last_addr", 32'(imem_addr), 32'd1023);
    check("full_last_data", 32'(imem_wdata), 32'h03FF);
    check_done("full", 1024);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
